// File: rtl/disp_arbiter_if.sv
// Bundles the requester-side handshake and display-driver outputs of disp_arbiter.
interface disp_arbiter_if;
   logic        req0;
   logic [15:0] data0;
   logic        req1;
   logic [15:0] data1;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  dig1;
   logic [3:0]  dig2;
   logic [3:0]  dig3;
   logic [3:0]  dig4;
   logic        blank;

   // Requester / display side: raises requests, observes grants and digits.
   modport master (
      output req0, data0, req1, data1,
      input  gnt0, gnt1, dig1, dig2, dig3, dig4, blank
   );

   // Arbiter side.
   modport slave (
      input  req0, data0, req1, data1,
      output gnt0, gnt1, dig1, dig2, dig3, dig4, blank
   );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the 4-digit display between two requesters.
// The owner keeps the display for at least HOLD cycles before the other
// requester may preempt it; digits and blank follow the next owner with the
// same one-cycle latency as the grants.
module disp_arbiter #(
   parameter int unsigned HOLD = 25_000_000,
   parameter int unsigned CW   = 25
) (
   input  logic           clk,
   input  logic           rst,
   disp_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [CW-1:0] LP_MAX = CW'(HOLD - 1);
   localparam logic [CW-1:0] LP_ONE = CW'(1);

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_ptr;      // 0 favours req0, 1 favours req1
   logic [15:0]     r_dig;
   logic            r_blank;
   logic            w_enter;
   logic [15:0]     w_data;

   // Next-state selection, entry detection and next-owner data mux.
   always_comb begin
      w_next  = r_state;
      w_enter = 1'b0;
      w_data  = '0;
      case (r_state)
         IDLE: begin
            if (bus.req0 && bus.req1) w_next = r_ptr ? OWN1 : OWN0;
            else if (bus.req0)        w_next = OWN0;
            else if (bus.req1)        w_next = OWN1;
         end
         OWN0: begin
            if (!bus.req0)                       w_next = bus.req1 ? OWN1 : IDLE;
            else if (bus.req1 && r_cnt == LP_MAX) w_next = OWN1;
         end
         OWN1: begin
            if (!bus.req1)                       w_next = bus.req0 ? OWN0 : IDLE;
            else if (bus.req0 && r_cnt == LP_MAX) w_next = OWN0;
         end
         default: w_next = IDLE;
      endcase
      w_enter = (w_next != r_state) && (w_next != IDLE);
      case (w_next)
         OWN0:    w_data = bus.data0;
         OWN1:    w_data = bus.data1;
         default: w_data = '0;
      endcase
   end

   // State, dwell counter, round-robin pointer and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= 1'b0;
         r_dig   <= '0;
         r_blank <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_enter)
            r_cnt <= '0;
         else if (r_state != IDLE && r_cnt != LP_MAX)
            r_cnt <= r_cnt + LP_ONE;
         if (w_enter)
            r_ptr <= (w_next == OWN0);
         r_dig   <= w_data;
         r_blank <= (w_next == IDLE);
      end
   end

   assign bus.gnt0  = (r_state == OWN0);
   assign bus.gnt1  = (r_state == OWN1);
   assign bus.dig1  = r_dig[15:12];
   assign bus.dig2  = r_dig[11:8];
   assign bus.dig3  = r_dig[7:4];
   assign bus.dig4  = r_dig[3:0];
   assign bus.blank = r_blank;

endmodule
